// File: rtl/reg_swap_engine.sv
// Command-driven exchange unit for four WIDTH-bit registers (write / swap over valid-ready).
// Define SWAP_TEMPLESS_EN for a single-cycle swap; the default is a three-step swap through temp.
module reg_swap_engine #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_op,
   input  logic [1:0]           cmd_idx_a,
   input  logic [1:0]           cmd_idx_b,
   input  logic [WIDTH-1:0]     cmd_wdata,
   output logic [4*WIDTH-1:0]   regs_flat,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MOV  = 2'd1;
   localparam logic [1:0] RST  = 2'd2;

   logic [WIDTH-1:0] regs_q [4];
   logic [WIDTH-1:0] regs_d [4];
   logic [WIDTH-1:0] temp_q, temp_d;
   logic [1:0]       state_q, state_d;
   logic [1:0]       idx_a_q, idx_a_d;
   logic [1:0]       idx_b_q, idx_b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept_s;

   assign cmd_ready = (state_q == IDLE);
   assign accept_s  = cmd_valid && cmd_ready;
   assign busy      = busy_q;
   assign done      = done_q;

   // Next-state logic; the TMP step is folded into the accept edge.
   always_comb begin
      regs_d  = regs_q;
      temp_d  = temp_q;
      state_d = state_q;
      idx_a_d = idx_a_q;
      idx_b_d = idx_b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (cmd_op == 1'b0) begin
                  regs_d[cmd_idx_a] = cmd_wdata;
                  done_d            = 1'b1;
               end else begin
`ifdef SWAP_TEMPLESS_EN
                  regs_d[cmd_idx_a] = regs_q[cmd_idx_b];
                  regs_d[cmd_idx_b] = regs_q[cmd_idx_a];
                  done_d            = 1'b1;
`else
                  idx_a_d = cmd_idx_a;
                  idx_b_d = cmd_idx_b;
                  temp_d  = regs_q[cmd_idx_a];
                  state_d = MOV;
                  busy_d  = 1'b1;
`endif
               end
            end else begin
               state_d = IDLE;
            end
         end
         MOV: begin
            regs_d[idx_a_q] = regs_q[idx_b_q];
            state_d         = RST;
         end
         RST: begin
            regs_d[idx_b_q] = temp_q;
            done_d          = 1'b1;
            busy_d          = 1'b0;
            state_d         = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset drops any partial swap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= WIDTH'(i + 1);
         end
         temp_q  <= '0;
         state_q <= IDLE;
         idx_a_q <= 2'd0;
         idx_b_q <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         temp_q  <= temp_d;
         state_q <= state_d;
         idx_a_q <= idx_a_d;
         idx_b_q <= idx_b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Flatten the register file onto the output bus.
   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < 4; i++) begin
         regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
      end
   end

endmodule

// File: tb/tb_reg_swap_engine.sv
// Scoreboard bench for reg_swap_engine: stimulus pushes expected results, a monitor checks them on done.
module tb_reg_swap_engine;

`ifdef SWAP_TEMPLESS_EN
   localparam bit TEMPLESS = 1'b1;
`else
   localparam bit TEMPLESS = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [1:0]  cmd_idx_a;
   logic [1:0]  cmd_idx_b;
   logic [3:0]  cmd_wdata;
   logic [15:0] regs_flat;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [3:0]  m_regs [4];
   logic [3:0]  m_temp;
   logic [15:0] q_regs [$];
   logic [3:0]  q_temp [$];
   int          q_cyc  [$];

   reg_swap_engine #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_idx_a (cmd_idx_a),
      .cmd_idx_b (cmd_idx_b),
      .cmd_wdata (cmd_wdata),
      .regs_flat (regs_flat),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] m_flat();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   // Monitor: every done pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q_cyc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
         end else begin
            chk("done_cycle", 32'(cyc), 32'(q_cyc.pop_front()));
            chk("done_regs", {16'h0, regs_flat}, {16'h0, q_regs.pop_front()});
            chk("done_temp", {28'h0, dut.temp_q}, {28'h0, q_temp.pop_front()});
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 4'(i + 1);
      m_temp = 4'h0;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Called at a negedge; returns at the negedge after the accept edge with valid dropped.
   task automatic issue(input logic op, input logic [1:0] a, input logic [1:0] b,
                        input logic [3:0] wd, input bit push, output int waits);
      int acc;
      logic [3:0] t;
      waits = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx_a = a;
      cmd_idx_b = b;
      cmd_wdata = wd;
      while (!cmd_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 20 cycles");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) begin
         if (op == 1'b0) begin
            m_regs[a] = wd;
         end else begin
            t = m_regs[a];
            if (!TEMPLESS) m_temp = t;
            m_regs[a] = m_regs[b];
            m_regs[b] = t;
         end
         q_regs.push_back(m_flat());
         q_temp.push_back(m_temp);
         q_cyc.push_back(acc + ((op && !TEMPLESS) ? 2 : 0));
      end
      @(negedge clk);
      chk("busy_after_accept", {31'h0, busy}, {31'h0, op && !TEMPLESS});
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q_cyc.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(q_cyc.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = 1'b0;
      cmd_idx_a = 2'd0;
      cmd_idx_b = 2'd0;
      cmd_wdata = 4'h0;
      @(negedge clk);
      do_reset();
      @(negedge clk);

      chk("reset_regs", {16'h0, regs_flat}, 32'h0000_4321);
      chk("reset_busy", {31'h0, busy}, 32'd0);
      chk("reset_ready", {31'h0, cmd_ready}, 32'd1);
      chk("reset_done", {31'h0, done}, 32'd0);

      // Swap 0/1 from reset.
      issue(1'b1, 2'd0, 2'd1, 4'h0, 1'b1, w);
      drain();
      chk("swap01_regs", {16'h0, regs_flat}, 32'h0000_4312);
      chk("swap01_temp", {28'h0, dut.temp_q}, TEMPLESS ? 32'h0 : 32'h1);

      // Write then swap from a clean reset.
      do_reset();
      issue(1'b0, 2'd2, 2'd0, 4'hA, 1'b1, w);
      chk("write_wait", 32'(w), 32'd0);
      drain();
      chk("write_regs", {16'h0, regs_flat}, 32'h0000_4A21);
      issue(1'b1, 2'd2, 2'd3, 4'h0, 1'b1, w);
      drain();
      chk("swap23_regs", {16'h0, regs_flat}, 32'h0000_A421);

      // Self-swap with valid held; second command waits for cmd_ready.
      issue(1'b1, 2'd3, 2'd3, 4'h0, 1'b1, w);
      issue(1'b1, 2'd0, 2'd1, 4'h0, 1'b1, w);
      chk("held_wait_cycles", 32'(w), TEMPLESS ? 32'd0 : 32'd2);
      drain();
      chk("self_then_swap_regs", {16'h0, regs_flat}, 32'h0000_A412);
      chk("self_then_swap_temp", {28'h0, dut.temp_q}, TEMPLESS ? 32'h0 : 32'h1);

      // Reset at the MOV edge discards the swap.
      issue(1'b1, 2'd0, 2'd1, 4'h0, TEMPLESS, w);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      drain();
      chk("midreset_regs", {16'h0, regs_flat}, 32'h0000_4321);
      chk("midreset_ready", {31'h0, cmd_ready}, 32'd1);
      chk("midreset_busy", {31'h0, busy}, 32'd0);
      chk("midreset_state", {30'h0, dut.state_q}, 32'd0);

      // Consecutive swaps 0/1 then 2/3.
      issue(1'b1, 2'd0, 2'd1, 4'h0, 1'b1, w);
      issue(1'b1, 2'd2, 2'd3, 4'h0, 1'b1, w);
      chk("b2b_wait_cycles", 32'(w), TEMPLESS ? 32'd0 : 32'd2);
      drain();
      chk("b2b_regs", {16'h0, regs_flat}, 32'h0000_3412);
      chk("model_agrees", {16'h0, regs_flat}, {16'h0, m_flat()});

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_swap_engine.md
# reg_swap_engine

Command-driven register exchange unit: owns four WIDTH-bit registers and executes write and swap commands issued by an initiator over a valid/ready handshake. It is the responder side of the swap stimulus used in our benches: instead of free-running exchanges on every clock, it performs exactly one requested exchange per accepted command and reports completion. By default a swap runs as a three-step sequence through a temp register; an optional single-cycle temp-less exchange is compiled in with a macro.

## Interface
- WIDTH, 4, bit width of each register and of temp
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command this cycle
- cmd_op  input  1  0 = write, 1 = swap
- cmd_idx_a  input  2  write target / first swap operand
- cmd_idx_b  input  2  second swap operand (ignored for write)
- cmd_wdata  input  WIDTH  write data
- regs_flat  output  4*WIDTH  reg[i] at bits [i*WIDTH +: WIDTH]
- busy  output  1  swap sequence in progress
- done  output  1  one-cycle pulse, command completed

## Operation
- Reset (rst_n low at a rising edge): reg0..reg3 = 1,2,3,4; temp = 0; state = IDLE; done = 0; busy = 0; cmd_ready = 1 once state is IDLE. While rst_n is low, commands are not accepted.
- Accept = cmd_valid && cmd_ready at a rising edge. cmd_ready = (state == IDLE), combinational from state.
- Write: reg[idx_a] <= wdata on the accept edge; done = 1 for the following cycle; state stays IDLE.
- Swap (default): FSM IDLE -> TMP -> MOV -> RST -> IDLE.
  - Accept edge: latch idx_a/idx_b; temp <= reg[a]; state <= MOV; busy <= 1.
  - MOV edge: reg[a] <= reg[b]; state <= RST.
  - RST edge: reg[b] <= temp; done <= 1; busy <= 0; state <= IDLE.
- The TMP step is folded into the accept edge, so the FSM visibly occupies MOV and RST only.
- Latched indices are used throughout the sequence; input changes after accept have no effect.
- idx_a == idx_b: full sequence runs, register unchanged, done pulses.
- temp keeps its last value after a swap; it is not cleared.
- cmd_valid held while busy: not accepted; the initiator keeps it asserted until cmd_ready.
- Reset mid-swap: the partial exchange is discarded, all registers return to 1,2,3,4, and no done pulse is produced.

## Timing
- Write: accept at edge T; regs_flat updated after T; done high in cycle T..T+1; next accept possible at T+1.
- Swap (default): accept at T; reg[a] updated after T+1; reg[b] updated after T+2; done high in cycle T+2..T+3; cmd_ready low in cycles T..T+2; earliest next accept at T+3. Throughput is one swap per 3 cycles.
- done and busy are registered outputs; regs_flat is a direct register output with no extra latency.

## Configuration
- SWAP_TEMPLESS_EN defined: a swap executes on the accept edge as a parallel nonblocking exchange (reg[a] <= reg[b], reg[b] <= reg[a]).
  - temp is untouched and MOV/RST are unused.
  - busy stays 0 and cmd_ready stays 1.
  - done pulses in cycle T..T+1.
  - Back-to-back swaps are allowed every cycle.
- Undefined: the three-step temp sequence described above.
- Register results are identical in both builds; only latency, busy, and temp differ.

## Test plan
- Reset then idle: regs_flat = 16'h4321, busy = 0, cmd_ready = 1, done = 0.
- Swap a=0, b=1 from reset: after done, regs_flat = 16'h4312, temp = 1; done pulses exactly once, 3 cycles after accept (1 cycle with SWAP_TEMPLESS_EN).
- Write idx 2 = 4'hA, then swap a=2, b=3: regs_flat = 16'hA421.
- Swap a=3, b=3 with cmd_valid held high across the sequence: register unchanged; a second command is accepted only at T+3, with cmd_ready low in between.
- Swap a=0, b=1 with rst_n low at the MOV edge: regs_flat = 16'h4321, no done, state IDLE.
- SWAP_TEMPLESS_EN: swaps 0/1 and 2/3 on consecutive cycles: regs_flat = 16'h3412, done high for 2 consecutive cycles.
